up_down_pulse_encoder: RTL and testbench
========================================

# up_down_pulse_encoder

Transmit-side companion of the sample-window up/down counter: accepts signed step requests over a valid/ready handshake and replays each as a train of single-cycle `up` or `down` pulses. A downstream up/down counter driven by these outputs moves by exactly the requested amount. Sits between the 200 kHz sample-domain control logic and the counter, in the same clock domain.

## Interface
- `WIDTH`, 19: width of `delta_in` and of the optional tracking count. Two's complement, 18 bits magnitude plus sign.
- `GAP`, 0: number of idle cycles forced between consecutive pulses. Range 0..255.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `delta_in`  in  WIDTH  signed step request.
- `delta_valid`  in  1  request valid.
- `delta_ready`  out  1  block can accept a request.
- `flush`  in  1  abort the remaining pulses of the current request.
- `up`  out  1  one-cycle increment pulse, registered.
- `down`  out  1  one-cycle decrement pulse, registered.
- `busy`  out  1  request in progress.
- `done`  out  1  one-cycle pulse: request completed normally.
- `track_count`  out  WIDTH  mirror of downstream count. Present only with `UDPE_TRACK_EN`.

## Operation
- States:
  - IDLE: waiting for a request.
  - EMIT: driving a pulse this cycle.
  - WAIT: counting `GAP` idle cycles.
- `delta_ready` = (state==IDLE) & !flush & !reset. This is the only combinational output.
- Accept on `delta_valid & delta_ready`:
  - Latch direction = sign bit of `delta_in`.
  - Latch `remaining` = |delta_in| as WIDTH-bit unsigned. The most-negative input (-2^(WIDTH-1)) gives 2^(WIDTH-1) pulses with no overflow.
- Zero request: accepted, no pulses, `done` pulses once; returns to IDLE.
- IDLE -> EMIT on a nonzero accept.
- EMIT:
  - Assert `up` if the direction is positive, otherwise `down`. Decrement `remaining`.
  - If `remaining` becomes 0: assert `done` and go to IDLE.
  - Else if GAP > 0: go to WAIT with the gap timer loaded to GAP.
  - Else stay in EMIT.
- WAIT -> EMIT when the gap timer reaches 0.
- `flush` in EMIT or WAIT: go to IDLE at the next edge, clear `remaining`, emit no further pulses, no `done`. In IDLE, `flush` is ignored except that it masks `delta_ready`.
- `up` and `down` are never high in the same cycle.
- `busy` = state != IDLE.
- Reset value 0 for `up`, `down`, `busy`, `done`, `remaining` and `track_count`. Reset state is IDLE.
- `reset` mid-request discards the request immediately. No pulse appears in the cycle after reset is sampled.

## Timing
- Accept edge at cycle T.
- Pulse k (k = 0..N-1) is high in cycle T+1+k·(GAP+1).
- `done` is high in the same cycle as the last pulse. For a zero request, `done` is high in T+1.
- `delta_ready` rises in the cycle after `done`. Back-to-back requests therefore have exactly one idle cycle between trains.
- `flush` sampled at edge F: `up`/`down`/`busy` are 0 from cycle F+1. Any pulse already visible in cycle F stands and is counted.
- Throughput with GAP=0 is one pulse per clock, matching the counter's one-step-per-clock rate.

## Configuration
- `UDPE_TRACK_EN` defined:
  - `track_count` port exists.
  - It is +1 on the edge after each `up` pulse and -1 on the edge after each `down` pulse.
  - It wraps modulo 2^WIDTH and resets to 0.
  - It is bit-identical to a downstream up/down counter of equal WIDTH sharing `clk`/`reset`.
- Not defined: port and logic absent; pulse behaviour is unchanged.

## Structure
- Shared package `udpe_pkg`:
  - State encoding (IDLE/EMIT/WAIT).
  - Default WIDTH constant 19.
  - Sample-window length constant 200000.
- Sub-module `pulse_gap_timer`: 8-bit loadable down-counter with load/zero flag. It is instantiated only when GAP > 0; otherwise tied off.

## Test plan
- Reset release, request +5, GAP=0 -> `up` high at T+1..T+5, `done` at T+5, `track_count`=5, `down` never high.
- Request -3, GAP=2 -> `down` at T+1, T+4, T+7; `done` at T+7; `busy` low at T+8; `track_count`=-3 (0x7FFFD).
- Request 0 -> no pulses, `done` at T+1, `delta_ready` high at T+2.
- Request -262144 (WIDTH=19) -> exactly 262144 `down` pulses, `track_count` = 0x40000.
- Request +10, `flush` sampled after the 4th pulse -> exactly 4 `up` pulses, no `done`, `delta_ready` high the cycle after flush.
- Request +1000, `reset` asserted mid-train for 1 cycle -> all outputs 0 the next cycle, `track_count`=0, and a new request of +2 is accepted normally afterward.

Source files
------------

// File: rtl/udpe_pkg.sv
// Shared definitions for up_down_pulse_encoder: FSM state encoding, default
// sizing and the sample-window length of the surrounding control logic.
package udpe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_WAIT = 2'd2
  } udpe_state_e;

  localparam int UDPE_WIDTH         = 19;
  localparam int UDPE_GAP_W         = 8;
  localparam int UDPE_SAMPLE_WINDOW = 200000;

endpackage

// File: rtl/pulse_gap_timer.sv
// 8-bit loadable down-counter that spaces pulses; zero_o flags an expired gap.
module pulse_gap_timer
  import udpe_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [UDPE_GAP_W-1:0] load_val_i,
  output logic                  zero_o
);

  logic [UDPE_GAP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - UDPE_GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/up_down_pulse_encoder.sv
// Replays signed step requests as trains of single-cycle up/down pulses.
// Define UDPE_TRACK_EN to add the track_count mirror of the downstream counter.
//
// state   | meaning
// IDLE    | waiting for a request
// EMIT    | a pulse (or the done of a zero request) is visible this cycle
// WAIT    | counting idle gap cycles before the next pulse
module up_down_pulse_encoder
  import udpe_pkg::*;
#(
  parameter int WIDTH = UDPE_WIDTH,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] delta_in,
  input  logic             delta_valid,
  output logic             delta_ready,
  input  logic             flush,
  output logic             up,
  output logic             down,
  output logic             busy,
  output logic             done
`ifdef UDPE_TRACK_EN
  ,
  output logic [WIDTH-1:0] track_count
`endif
);

  // The gap timer spends GAP cycles in WAIT, the last of them showing zero.
  localparam logic [UDPE_GAP_W-1:0] GAP_LOAD = UDPE_GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  udpe_state_e      state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] mag, pulse_src;
  logic             neg_q, neg_d;
  logic             up_q, up_d, down_q, down_d;
  logic             done_q, done_d, busy_q, busy_d;
  logic             accept, fire, timer_load, timer_zero;

  assign delta_ready = (state_q == ST_IDLE) & ~flush & ~reset;
  assign accept      = delta_valid & delta_ready;
  assign mag         = delta_in[WIDTH-1] ? (~delta_in + WIDTH'(1)) : delta_in;

  // Outputs are registered from the next-state decode, so state_q always
  // describes what up/down/done currently show.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    neg_d      = neg_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    done_d     = 1'b0;
    timer_load = 1'b0;
    fire       = 1'b0;
    pulse_src  = rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          neg_d = delta_in[WIDTH-1];
          if (mag == '0) begin
            state_d = ST_EMIT;
            done_d  = 1'b1;
            rem_d   = '0;
          end else begin
            fire      = 1'b1;
            pulse_src = mag;
          end
        end
      end
      ST_EMIT: begin
        if (rem_q == '0) begin
          state_d = ST_IDLE;
        end else if (GAP > 0) begin
          state_d    = ST_WAIT;
          timer_load = 1'b1;
        end else begin
          fire = 1'b1;
        end
      end
      ST_WAIT: begin
        if (timer_zero) begin
          fire = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fire) begin
      state_d = ST_EMIT;
      up_d    = ~neg_d;
      down_d  = neg_d;
      rem_d   = pulse_src - WIDTH'(1);
      done_d  = (pulse_src == WIDTH'(1));
    end

    if (flush && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      rem_d      = '0;
      up_d       = 1'b0;
      down_d     = 1'b0;
      done_d     = 1'b0;
      timer_load = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      up_q    <= up_d;
      down_q  <= down_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  if (GAP > 0) begin : g_gap
    pulse_gap_timer u_gap_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (timer_load),
      .load_val_i (GAP_LOAD),
      .zero_o     (timer_zero)
    );
  end else begin : g_no_gap
    logic gap_unused;
    assign gap_unused = timer_load;
    assign timer_zero = 1'b1;
  end

  assign up   = up_q;
  assign down = down_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef UDPE_TRACK_EN
  logic [WIDTH-1:0] track_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      track_q <= '0;
    end else if (up_q) begin
      track_q <= track_q + WIDTH'(1);
    end else if (down_q) begin
      track_q <= track_q - WIDTH'(1);
    end
  end

  assign track_count = track_q;
`endif

endmodule

// File: tb/tb_up_down_pulse_encoder.sv
// Self-checking bench for up_down_pulse_encoder: a full-width GAP=0 instance
// and a narrow GAP=2 instance (narrow so the most-negative request stays short).
module tb_up_down_pulse_encoder;

  localparam int WA = 19;
  localparam int GA = 0;
  localparam int WB = 11;
  localparam int GB = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WA-1:0] a_delta = '0;
  logic          a_valid = 1'b0, a_flush = 1'b0;
  logic          a_ready, a_up, a_down, a_busy, a_done;
  logic [WB-1:0] b_delta = '0;
  logic          b_valid = 1'b0, b_flush = 1'b0;
  logic          b_ready, b_up, b_down, b_busy, b_done;
`ifdef UDPE_TRACK_EN
  logic [WA-1:0] a_track;
  logic [WB-1:0] b_track;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [4:0]  rec[$];
  int          n_up, n_dn, n_done;
  longint      exp_trk[2];

  always #5 clk = ~clk;

  up_down_pulse_encoder #(.WIDTH(WA), .GAP(GA)) u_dut_a (
    .clk(clk), .reset(reset), .delta_in(a_delta), .delta_valid(a_valid),
    .delta_ready(a_ready), .flush(a_flush), .up(a_up), .down(a_down),
    .busy(a_busy), .done(a_done)
`ifdef UDPE_TRACK_EN
    , .track_count(a_track)
`endif
  );

  up_down_pulse_encoder #(.WIDTH(WB), .GAP(GB)) u_dut_b (
    .clk(clk), .reset(reset), .delta_in(b_delta), .delta_valid(b_valid),
    .delta_ready(b_ready), .flush(b_flush), .up(b_up), .down(b_down),
    .busy(b_busy), .done(b_done)
`ifdef UDPE_TRACK_EN
    , .track_count(b_track)
`endif
  );

  function automatic int gapof(bit s);
    return s ? GB : GA;
  endfunction

  function automatic longint mask(bit s);
    return (longint'(1) << (s ? WB : WA)) - 1;
  endfunction

  // {up, down, done, busy, delta_ready}
  function automatic logic [4:0] obs(bit s);
    return s ? {b_up, b_down, b_done, b_busy, b_ready} : {a_up, a_down, a_done, a_busy, a_ready};
  endfunction

  function automatic logic cur_valid(bit s);
    return s ? b_valid : a_valid;
  endfunction

`ifdef UDPE_TRACK_EN
  function automatic longint o_track(bit s);
    return s ? longint'(b_track) : longint'(a_track);
  endfunction
`endif

  task automatic set_in(bit s, logic v, longint d);
    if (s) begin b_valid = v; b_delta = WB'(d); end
    else   begin a_valid = v; a_delta = WA'(d); end
  endtask

  task automatic set_flush(bit s, logic f);
    if (s) b_flush = f; else a_flush = f;
  endtask

  // Reference timing: pulse k sits k*(gap+1) cycles after the accept edge,
  // done with the last pulse, ready returns the cycle after the train ends.
  function automatic int last_idx(longint n, int g);
    return (n == 0) ? 0 : int'(n - 1) * (g + 1);
  endfunction

  function automatic logic [4:0] expect_bits(int j, longint n, bit neg, int g, int cut);
    int   lst  = last_idx(n, g);
    int   stop = (cut >= 0 && cut < lst) ? cut : lst;
    logic p    = (j % (g + 1) == 0) && (longint'(j / (g + 1)) < n) && (j <= stop);
    return {p & ~neg, p & neg, (j == lst) && (lst <= stop), j <= stop, (j > stop) && (j != cut)};
  endfunction

  function automatic longint kept(longint n, int g, int cut);
    if (n == 0) return 0;
    if (cut < 0 || cut >= last_idx(n, g)) return n;
    return longint'(cut / (g + 1) + 1);
  endfunction

  function automatic int trace_errs(longint n, bit neg, int g, int cut);
    int e = 0;
    for (int j = 0; j < rec.size(); j++)
      if (rec[j] !== expect_bits(j, n, neg, g, cut)) e++;
    return e;
  endfunction

  task automatic issue(input bit s, input longint d, input logic nv, input longint nd, output bit ok);
    logic [4:0] o;
    ok = 1'b0;
    set_in(s, 1'b1, d);
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      o = obs(s);
      if (o[0] === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    set_in(s, nv, nd);
  endtask

  task automatic record(input bit s, input int len, input int flush_at, input int reset_at);
    logic [4:0] o;
    logic       drop;
    rec.delete();
    n_up = 0; n_dn = 0; n_done = 0;
    for (int j = 0; j < len; j++) begin
      set_flush(s, j == flush_at);
      reset = (j == reset_at);
      @(negedge clk);
      o = obs(s);
      rec.push_back(o);
      if (o[4] === 1'b1) n_up++;
      if (o[3] === 1'b1) n_dn++;
      if (o[2] === 1'b1) n_done++;
      drop = (o[0] === 1'b1) && (cur_valid(s) === 1'b1);
      @(posedge clk);
      #1;
      if (drop) set_in(s, 1'b0, 0);
    end
    set_flush(s, 1'b0);
    reset = 1'b0;
  endtask

  task automatic track_note(bit s, longint d);
    exp_trk[s] = (exp_trk[s] + d) & mask(s);
  endtask

  task automatic test_reset();
    logic [4:0] o;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    o = obs(0);
    n_checks++;
    if (o !== 5'b00000) $display("FAIL reset_held: got %b expected 00000", o); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_trk[0] = 0; exp_trk[1] = 0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = obs(1'(s));
      n_checks++;
      if (o !== 5'b00001) $display("FAIL reset_release[%0d]: got %b expected 00001", s, o); else n_pass++;
`ifdef UDPE_TRACK_EN
      n_checks++;
      if (o_track(1'(s)) !== 0) $display("FAIL reset_track[%0d]: got %0d expected 0", s, o_track(1'(s))); else n_pass++;
`endif
    end
  endtask

  task automatic test_plus5();
    bit ok;
    issue(0, 5, 1'b0, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL plus5_accept: got 0 expected 1"); else n_pass++;
    record(0, 10, -1, -1);
    track_note(0, 5);
    n_checks++;
    if (trace_errs(5, 0, GA, -1) != 0) $display("FAIL plus5_trace: got %0d bad cycles expected 0", trace_errs(5, 0, GA, -1)); else n_pass++;
    n_checks++;
    if (n_up != 5 || n_dn != 0) $display("FAIL plus5_count: got up=%0d down=%0d expected 5/0", n_up, n_dn); else n_pass++;
`ifdef UDPE_TRACK_EN
    n_checks++;
    if (o_track(0) !== exp_trk[0]) $display("FAIL plus5_track: got %0h expected %0h", o_track(0), exp_trk[0]); else n_pass++;
`endif
  endtask

  task automatic test_minus3_gap2();
    bit ok;
    issue(1, -3, 1'b0, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL minus3_accept: got 0 expected 1"); else n_pass++;
    record(1, 11, -1, -1);
    track_note(1, -3);
    n_checks++;
    if (trace_errs(3, 1, GB, -1) != 0) $display("FAIL minus3_trace: got %0d bad cycles expected 0", trace_errs(3, 1, GB, -1)); else n_pass++;
    n_checks++;
    if (rec[7][1] !== 1'b0 || rec[6][2] !== 1'b1) $display("FAIL minus3_done_busy: got done6=%b busy7=%b expected 1/0", rec[6][2], rec[7][1]); else n_pass++;
`ifdef UDPE_TRACK_EN
    n_checks++;
    if (o_track(1) !== exp_trk[1]) $display("FAIL minus3_track: got %0h expected %0h", o_track(1), exp_trk[1]); else n_pass++;
`endif
  endtask

  task automatic test_zero();
    bit ok;
    issue(0, 0, 1'b0, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL zero_accept: got 0 expected 1"); else n_pass++;
    record(0, 4, -1, -1);
    n_checks++;
    if (trace_errs(0, 0, GA, -1) != 0) $display("FAIL zero_trace: got %0d bad cycles expected 0", trace_errs(0, 0, GA, -1)); else n_pass++;
    n_checks++;
    if (rec[0][2] !== 1'b1 || rec[1][0] !== 1'b1 || n_up + n_dn != 0)
      $display("FAIL zero_done_ready: got done=%b ready=%b pulses=%0d expected 1/1/0", rec[0][2], rec[1][0], n_up + n_dn);
    else n_pass++;
  endtask

  task automatic test_most_negative();
    bit     ok;
    longint n = longint'(1) << (WB - 1);
    issue(1, -n, 1'b0, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL mostneg_accept: got 0 expected 1"); else n_pass++;
    record(1, last_idx(n, GB) + 4, -1, -1);
    track_note(1, -n);
    n_checks++;
    if (n_dn != int'(n) || n_up != 0 || n_done != 1)
      $display("FAIL mostneg_count: got down=%0d up=%0d done=%0d expected %0d/0/1", n_dn, n_up, n_done, n);
    else n_pass++;
    n_checks++;
    if (trace_errs(n, 1, GB, -1) != 0) $display("FAIL mostneg_trace: got %0d bad cycles expected 0", trace_errs(n, 1, GB, -1)); else n_pass++;
`ifdef UDPE_TRACK_EN
    n_checks++;
    if (o_track(1) !== exp_trk[1]) $display("FAIL mostneg_track: got %0h expected %0h", o_track(1), exp_trk[1]); else n_pass++;
`endif
  endtask

  task automatic test_flush();
    bit ok;
    issue(0, 10, 1'b0, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL flush_accept: got 0 expected 1"); else n_pass++;
    record(0, 8, 3, -1);
    track_note(0, 4);
    n_checks++;
    if (n_up != 4 || n_done != 0 || rec[4][0] !== 1'b1)
      $display("FAIL flush_stop: got up=%0d done=%0d ready4=%b expected 4/0/1", n_up, n_done, rec[4][0]);
    else n_pass++;
    n_checks++;
    if (trace_errs(10, 0, GA, 3) != 0) $display("FAIL flush_trace: got %0d bad cycles expected 0", trace_errs(10, 0, GA, 3)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    issue(0, 1000, 1'b0, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL rstmid_accept: got 0 expected 1"); else n_pass++;
    record(0, 10, -1, 6);
    exp_trk[0] = 0; exp_trk[1] = 0;
    n_checks++;
    if (rec[7][4:1] !== 4'b0000) $display("FAIL rstmid_quiet: got %b expected 0000", rec[7][4:1]); else n_pass++;
    n_checks++;
    if (trace_errs(1000, 0, GA, 6) != 0) $display("FAIL rstmid_trace: got %0d bad cycles expected 0", trace_errs(1000, 0, GA, 6)); else n_pass++;
`ifdef UDPE_TRACK_EN
    n_checks++;
    if (o_track(0) !== 0) $display("FAIL rstmid_track: got %0h expected 0", o_track(0)); else n_pass++;
`endif
    issue(0, 2, 1'b0, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL rstmid_reaccept: got 0 expected 1"); else n_pass++;
    record(0, 5, -1, -1);
    track_note(0, 2);
    n_checks++;
    if (trace_errs(2, 0, GA, -1) != 0) $display("FAIL rstmid_plus2: got %0d bad cycles expected 0", trace_errs(2, 0, GA, -1)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit         ok;
    int         g, l1, e;
    logic [4:0] ex;
    for (int s = 0; s < 2; s++) begin
      g  = gapof(1'(s));
      l1 = last_idx(3, g);
      issue(1'(s), 3, 1'b1, -2, ok);
      n_checks++;
      if (!ok) $display("FAIL b2b_accept[%0d]: got 0 expected 1", s); else n_pass++;
      record(1'(s), l1 + 2 + last_idx(2, g) + 3, -1, -1);
      track_note(1'(s), 1);
      e = 0;
      for (int j = 0; j < rec.size(); j++) begin
        ex = (j <= l1 + 1) ? expect_bits(j, 3, 0, g, -1) : expect_bits(j - (l1 + 2), 2, 1, g, -1);
        if (rec[j] !== ex) e++;
      end
      n_checks++;
      if (e != 0 || n_up != 3 || n_dn != 2)
        $display("FAIL b2b_trace[%0d]: got bad=%0d up=%0d down=%0d expected 0/3/2", s, e, n_up, n_dn);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit     s, neg, ok;
    int     g, cut, len, lst, e;
    longint n, kp;
    for (int it = 0; it < 24; it++) begin
      s   = 1'($urandom_range(0, 1));
      g   = gapof(s);
      n   = longint'($urandom_range(0, 20));
      neg = (n != 0) && ($urandom_range(0, 1) == 1);
      lst = last_idx(n, g);
      cut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, lst + 2)) : -1;
      len = ((cut > lst) ? cut : lst) + 3;
      issue(s, neg ? -n : n, 1'b0, 0, ok);
      n_checks++;
      if (!ok) $display("FAIL rand_accept[%0d]: got 0 expected 1", it); else n_pass++;
      if (ok) begin
        record(s, len, cut, -1);
        kp = kept(n, g, cut);
        track_note(s, neg ? -kp : kp);
        e = trace_errs(n, neg, g, cut);
        n_checks++;
        if (e != 0) $display("FAIL rand_trace[%0d]: got %0d bad cycles expected 0 (d=%0d cut=%0d)", it, e, neg ? -n : n, cut); else n_pass++;
        n_checks++;
        if (longint'(n_up - n_dn) != (neg ? -kp : kp)) $display("FAIL rand_net[%0d]: got %0d expected %0d", it, n_up - n_dn, neg ? -kp : kp); else n_pass++;
`ifdef UDPE_TRACK_EN
        n_checks++;
        if (o_track(s) !== exp_trk[s]) $display("FAIL rand_track[%0d]: got %0h expected %0h", it, o_track(s), exp_trk[s]); else n_pass++;
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_plus5();
    test_minus3_gap2();
    test_zero();
    test_most_negative();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
